// File: rtl/bullet_table.sv
// Bullet slot table feeding the VGA bullet bus: fire arbitration, per-frame sweep and kill.
// Optional per-player active cap is compiled in when BULLET_LIMIT_EN is defined.
module bullet_table #(
    parameter int MAX_BULLETS    = 64,
    parameter int BULLET_SIZE    = 12,
    parameter int SPRITE_SIZE    = 64,
    parameter int SPEED          = 4,
    parameter int MAX_PER_PLAYER = 8
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           frame_tick,
    input  logic [127:0]                   allSpriteContents,
    input  logic [1:0]                     fire_req,
    input  logic [3:0]                     fire_dir,
    output logic [1:0]                     fire_ack,
    input  logic                           kill_valid,
    input  logic [$clog2(MAX_BULLETS)-1:0] kill_idx,
    output logic [32*MAX_BULLETS-1:0]      allBulletContents,
    output logic [$clog2(MAX_BULLETS):0]   active_count,
    output logic                           busy,
    output logic                           full
);
    localparam int IW = $clog2(MAX_BULLETS);
    localparam int CW = IW + 1;
    localparam logic [9:0]         SPAWN_X = 10'((SPRITE_SIZE - BULLET_SIZE) / 2);
    localparam logic [8:0]         SPAWN_Y = 9'((SPRITE_SIZE - BULLET_SIZE) / 2);
    localparam logic signed [10:0] X_MAX   = 11'(640 - BULLET_SIZE);
    localparam logic signed [10:0] Y_MAX   = 11'(480 - BULLET_SIZE);
    localparam logic signed [10:0] STEP    = 11'(SPEED);
    localparam logic signed [10:0] ZERO    = '0;

    typedef enum logic {S_IDLE, S_SWEEP} state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_pend;
    logic            r_busy;
    logic            r_full;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_slots [MAX_BULLETS];

    logic            w_can, w_ack0, w_ack1, w_grant;
    logic [1:0]      w_cap_ok;
    logic [IW-1:0]   w_free_idx;
    logic [31:0]     w_cur, w_step_word, w_spawn_word;
    logic signed [10:0] w_nx, w_ny;
    logic            w_oob, w_step, w_retire, w_kill_eff, w_inc;
    logic [CW-1:0]   w_count_nx;
    logic [9:0]      w_sx;
    logic [8:0]      w_sy;
    logic [1:0]      w_sdir;

    assign w_can    = (r_state == S_IDLE) && !r_full;
    assign w_ack0   = fire_req[0] && w_can && w_cap_ok[0];
    assign w_ack1   = fire_req[1] && w_can && w_cap_ok[1] && !w_ack0;
    assign w_grant  = w_ack0 || w_ack1;
    assign fire_ack = {w_ack1, w_ack0};

    // Lowest-index inactive slot receives the next shot.
    always_comb begin
        w_free_idx = '0;
        for (int i = MAX_BULLETS - 1; i >= 0; i--) begin
            if (!r_slots[i][2]) w_free_idx = IW'(i);
        end
    end

    assign w_sx         = (w_ack1 ? allSpriteContents[73:64] : allSpriteContents[9:0]) + SPAWN_X;
    assign w_sy         = (w_ack1 ? allSpriteContents[104:96] : allSpriteContents[40:32]) + SPAWN_Y;
    assign w_sdir       = w_ack1 ? fire_dir[3:2] : fire_dir[1:0];
    assign w_spawn_word = {w_sx, w_sy, 8'd0, w_sdir, 1'b1, 1'b0, w_ack1};

    assign w_cur = r_slots[r_idx];

    always_comb begin
        w_nx = $signed({1'b0, w_cur[31:22]});
        w_ny = $signed({2'b00, w_cur[21:13]});
        case (w_cur[4:3])
            2'b00:   w_ny = w_ny - STEP;
            2'b01:   w_nx = w_nx + STEP;
            2'b10:   w_ny = w_ny + STEP;
            default: w_nx = w_nx - STEP;
        endcase
    end

    assign w_oob       = (w_nx < ZERO) || (w_nx > X_MAX) || (w_ny < ZERO) || (w_ny > Y_MAX);
    assign w_step_word = {w_nx[9:0], w_ny[8:0], 8'd0, w_cur[4:3], 1'b1, w_cur[1:0]};
    assign w_step      = (r_state == S_SWEEP) && w_cur[2];

    // A kill overrides a step or allocation of the same slot, so count it only once.
    assign w_kill_eff = kill_valid && r_slots[kill_idx][2];
    assign w_retire   = w_step && w_oob && !(kill_valid && (kill_idx == r_idx));
    assign w_inc      = w_grant && !(kill_valid && (kill_idx == w_free_idx));
    assign w_count_nx = r_count + CW'(w_inc) - CW'(w_kill_eff) - CW'(w_retire);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_BULLETS; i++) r_slots[i] <= '0;
        end else begin
            if (w_step)     r_slots[r_idx]      <= w_oob ? 32'd0 : w_step_word;
            if (w_grant)    r_slots[w_free_idx] <= w_spawn_word;
            if (kill_valid) r_slots[kill_idx]   <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else begin
            r_count <= w_count_nx;
            r_full  <= (w_count_nx == CW'(MAX_BULLETS));
            case (r_state)
                S_IDLE: begin
                    if (frame_tick || r_pend) begin
                        r_state <= S_SWEEP;
                        r_idx   <= '0;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    if (frame_tick) r_pend <= 1'b1;
                    if (r_idx == IW'(MAX_BULLETS - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
            endcase
        end
    end

`ifdef BULLET_LIMIT_EN
    logic [CW-1:0] r_pcnt0, r_pcnt1;
    logic          w_kill_own, w_step_own;

    assign w_kill_own = r_slots[kill_idx][0];
    assign w_step_own = w_cur[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pcnt0 <= '0;
            r_pcnt1 <= '0;
        end else begin
            r_pcnt0 <= r_pcnt0 + CW'(w_inc && !w_ack1) - CW'(w_kill_eff && !w_kill_own)
                       - CW'(w_retire && !w_step_own);
            r_pcnt1 <= r_pcnt1 + CW'(w_inc && w_ack1) - CW'(w_kill_eff && w_kill_own)
                       - CW'(w_retire && w_step_own);
        end
    end

    assign w_cap_ok = {r_pcnt1 < CW'(MAX_PER_PLAYER), r_pcnt0 < CW'(MAX_PER_PLAYER)};
`else
    assign w_cap_ok = 2'b11;
`endif

    logic w_unused;
    assign w_unused = ^{allSpriteContents[127:105], allSpriteContents[95:74],
                        allSpriteContents[63:41], allSpriteContents[31:10],
                        w_cur[12:5], MAX_PER_PLAYER[0]};

    for (genvar g = 0; g < MAX_BULLETS; g++) begin : g_bus
        assign allBulletContents[32*g +: 32] = r_slots[g];
    end

    assign active_count = r_count;
    assign busy         = r_busy;
    assign full         = r_full;
endmodule
